// File: rtl/pwm_capture.sv
// Pulse/PWM input capture: measures the period and active-phase width of pwm_in in prescaled ticks.
// Latency: an input edge becomes visible SYNC_STAGES+1 cycles after the pin; done/period/high are registered one cycle after the capture edge.
// Backpressure: none; each new capture overwrites period/high, and done/ovf are single-cycle strobes.
module pwm_capture #(
    parameter int CW          = 32,
    parameter int PRW         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    input  logic           en,
    input  logic           mode,
    input  logic           pol,
    input  logic [PRW-1:0] pr,
    input  logic           pwm_in,
    output logic [CW-1:0]  period,
    output logic [CW-1:0]  high,
    output logic           valid,
    output logic           done,
    output logic           ovf,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_ACTIVE   = 3'd2,
        S_INACTIVE = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_sync_d;

    logic                 r_mode_l;
    logic                 r_pol_l;
    logic [PRW-1:0]       r_pr_l;
    logic [PRW-1:0]       r_pr_cnt;

    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_hi_lat;
    logic [CW-1:0]        r_period;
    logic [CW-1:0]        r_high;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_s;
    logic                 w_s_d;
    logic                 w_start;
    logic                 w_end;
    logic                 w_tick;
    logic [CW-1:0]        w_cap;
    logic                 w_cnt_max;
    logic                 w_measuring;

    logic                 w_busy;
    logic                 w_arm;
    logic                 w_restart;
    logic                 w_capture;
    logic                 w_latch_hi;
    logic                 w_ovf_evt;

    // Both edges share the same delay chain so measured widths are not skewed by sync latency.
    // pol_l is applied to both taps, so a polarity change at arm time can never fake an edge.
    assign w_s         = r_sync[SYNC_STAGES-1] ^ r_pol_l;
    assign w_s_d       = r_sync_d ^ r_pol_l;
    assign w_start     = w_s & ~w_s_d;
    assign w_end       = ~w_s & w_s_d;
    assign w_tick      = (r_pr_cnt == r_pr_l);
    assign w_cap       = r_cnt + CW'(w_tick);
    assign w_cnt_max   = &r_cnt;
    assign w_measuring = (r_state == S_ACTIVE) || (r_state == S_INACTIVE);

    // Input synchronizer plus one extra flop for edge detection.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping en always wins and returns to IDLE without capturing.
    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     w_next = S_ARM;
                S_ARM:      if (w_start) w_next = S_ACTIVE;
                S_ACTIVE: begin
                    if (w_end)          w_next = S_INACTIVE;
                    else if (w_ovf_evt) w_next = S_ARM;
                end
                S_INACTIVE: begin
                    if (w_start)        w_next = r_mode_l ? S_ACTIVE : S_HOLD;
                    else if (w_ovf_evt) w_next = S_ARM;
                end
                S_HOLD:     w_next = S_HOLD;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // Output/event decode from the current state; an edge in the tick cycle beats overflow.
    always_comb begin
        w_busy     = (r_state == S_ARM) || w_measuring;
        w_arm      = (r_state == S_IDLE) && en;
        w_restart  = en && w_start && ((r_state == S_ARM) || (r_state == S_INACTIVE));
        w_capture  = en && w_start && (r_state == S_INACTIVE);
        w_latch_hi = en && w_end && (r_state == S_ACTIVE);
        w_ovf_evt  = en && w_measuring && w_cnt_max && w_tick && !w_start && !w_end;
    end

    // Configuration is frozen on arming so mid-measurement writes cannot corrupt a result.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mode_l <= 1'b0;
            r_pol_l  <= 1'b0;
            r_pr_l   <= '0;
        end else if (w_arm) begin
            r_mode_l <= mode;
            r_pol_l  <= pol;
            r_pr_l   <= pr;
        end
    end

    // Prescaler restarts with each measurement so tick phase is aligned to the start edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pr_cnt <= '0;
        end else if ((r_state == S_IDLE) || w_restart || w_tick) begin
            r_pr_cnt <= '0;
        end else begin
            r_pr_cnt <= r_pr_cnt + PRW'(1);
        end
    end

    // Tick counter; only meaningful while measuring, held at zero otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= '0;
        end else if (!w_measuring || w_restart) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Active-phase width is parked here until the period completes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_hi_lat <= '0;
        end else if (w_latch_hi) begin
            r_hi_lat <= w_cap;
        end
    end

    // Published results and single-cycle strobes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_period <= '0;
            r_high   <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_capture;
            r_ovf  <= w_ovf_evt;
            if (w_capture) begin
                r_period <= w_cap;
                r_high   <= r_hi_lat;
                r_valid  <= 1'b1;
            end
        end
    end

    assign period = r_period;
    assign high   = r_high;
    assign valid  = r_valid;
    assign done   = r_done;
    assign ovf    = r_ovf;
    assign busy   = w_busy;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 32-bit instance for functional cases and an 8-bit instance for overflow.
// Expected values are hand-derived from the waveforms driven below.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled away from the edge.
module tb_pwm_capture;

    logic        PCLK;
    logic        PRESETn;
    logic        en;
    logic        en8;
    logic        mode;
    logic        pol;
    logic [15:0] pr;
    logic        pwm_in;

    logic [31:0] period;
    logic [31:0] high;
    logic        valid;
    logic        done;
    logic        ovf;
    logic        busy;

    logic [7:0]  period8;
    logic [7:0]  high8;
    logic        valid8;
    logic        done8;
    logic        ovf8;
    logic        busy8;

    int n_checks = 0;
    int n_errors = 0;

    int cyc_cnt       = 0;
    int done_cnt      = 0;
    int ovf_cnt       = 0;
    int both_cnt      = 0;
    int done8_cnt     = 0;
    int ovf8_cnt      = 0;
    int ovf8_cyc      = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    pwm_capture #(.CW(32), .PRW(16), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (en),
        .mode    (mode),
        .pol     (pol),
        .pr      (pr),
        .pwm_in  (pwm_in),
        .period  (period),
        .high    (high),
        .valid   (valid),
        .done    (done),
        .ovf     (ovf),
        .busy    (busy)
    );

    pwm_capture #(.CW(8), .PRW(16), .SYNC_STAGES(2)) dut8 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (en8),
        .mode    (mode),
        .pol     (pol),
        .pr      (pr),
        .pwm_in  (pwm_in),
        .period  (period8),
        .high    (high8),
        .valid   (valid8),
        .done    (done8),
        .ovf     (ovf8),
        .busy    (busy8)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge PCLK) begin
        if (done) begin
            done_cnt      = done_cnt + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc_cnt;
        end
        if (ovf) ovf_cnt = ovf_cnt + 1;
        if (done && ovf) both_cnt = both_cnt + 1;
        if (done8) done8_cnt = done8_cnt + 1;
        if (ovf8) begin
            ovf8_cnt = ovf8_cnt + 1;
            ovf8_cyc = cyc_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // n periods of: pwm_in high for hi cycles, then low for lo cycles.
    task automatic pulse_train(input int hi, input int lo, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            cycles(hi);
            pwm_in = 1'b0;
            cycles(lo);
        end
    endtask

    // n periods of: pwm_in low for lo cycles, then high for hi cycles.
    task automatic low_train(input int lo, input int hi, input int n);
        repeat (n) begin
            pwm_in = 1'b0;
            cycles(lo);
            pwm_in = 1'b1;
            cycles(hi);
        end
    endtask

    initial begin
        int d0;
        int d1;
        int rise_cyc;

        PRESETn = 1'b0;
        en      = 1'b0;
        en8     = 1'b0;
        mode    = 1'b1;
        pol     = 1'b0;
        pr      = 16'd0;
        pwm_in  = 1'b0;
        cycles(2);

        // Reset state
        check("rst_period", period, 32'd0);
        check("rst_high",   high,   32'd0);
        check("rst_valid",  32'(valid), 32'd0);
        check("rst_done",   32'(done),  32'd0);
        check("rst_ovf",    32'(ovf),   32'd0);
        check("rst_busy",   32'(busy),  32'd0);
        PRESETn = 1'b1;
        cycles(3);

        // Continuous, pr=0, 10-cycle period with 3 high: five captures from six rising edges
        en = 1'b1;
        cycles(3);
        check("t1_busy_armed", 32'(busy), 32'd1);
        d0 = done_cnt;
        pulse_train(3, 7, 6);
        check("t1_done_count", 32'(done_cnt - d0), 32'd5);
        check("t1_period", period, 32'd10);
        check("t1_high",   high,   32'd3);
        check("t1_valid",  32'(valid), 32'd1);
        check("t1_done_gap", 32'(last_done_cyc - prev_done_cyc), 32'd10);

        // pr=4: 50/20 cycles -> 10/4 ticks; pr change while busy is ignored
        en = 1'b0;
        pr = 16'd4;
        cycles(1);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        pulse_train(20, 30, 3);
        check("t2_done_count", 32'(done_cnt - d0), 32'd2);
        check("t2_period", period, 32'd10);
        check("t2_high",   high,   32'd4);
        pr = 16'd9;
        d0 = done_cnt;
        pulse_train(20, 30, 3);
        check("t2_busy_pr_done", 32'(done_cnt - d0), 32'd3);
        check("t2_busy_pr_period", period, 32'd10);
        check("t2_busy_pr_high",   high,   32'd4);
        en = 1'b0;
        cycles(1);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        pulse_train(20, 30, 3);
        check("t2_pr9_done",   32'(done_cnt - d0), 32'd2);
        check("t2_pr9_period", period, 32'd5);
        check("t2_pr9_high",   high,   32'd2);

        // pol=1: low 7 / high 13 -> active width 7, period 20
        en     = 1'b0;
        pol    = 1'b1;
        pr     = 16'd0;
        pwm_in = 1'b1;
        cycles(5);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        low_train(7, 13, 3);
        check("t3_done_count", 32'(done_cnt - d0), 32'd2);
        check("t3_period", period, 32'd20);
        check("t3_high",   high,   32'd7);

        // One-shot: exactly one capture, then HOLD until en toggles
        en     = 1'b0;
        pol    = 1'b0;
        mode   = 1'b0;
        pwm_in = 1'b0;
        cycles(5);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        pulse_train(3, 7, 4);
        check("t4_done_once", 32'(done_cnt - d0), 32'd1);
        check("t4_period", period, 32'd10);
        check("t4_high",   high,   32'd3);
        check("t4_hold_busy", 32'(busy), 32'd0);
        en = 1'b0;
        cycles(1);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        pulse_train(4, 8, 4);
        check("t4_rearm_done", 32'(done_cnt - d0), 32'd1);
        check("t4_rearm_period", period, 32'd12);
        check("t4_rearm_high",   high,   32'd4);
        check("t4_rearm_busy", 32'(busy), 32'd0);

        // en dropped mid-INACTIVE: no capture, previous result retained
        en   = 1'b0;
        mode = 1'b1;
        cycles(1);
        en = 1'b1;
        cycles(2);
        d0 = done_cnt;
        pulse_train(3, 7, 3);
        pwm_in = 1'b1;
        cycles(5);
        pwm_in = 1'b0;
        cycles(5);
        check("t5_pre_done", 32'(done_cnt - d0), 32'd3);
        d1 = done_cnt;
        en = 1'b0;
        cycles(1);
        pwm_in = 1'b1;
        cycles(5);
        pwm_in = 1'b0;
        cycles(5);
        check("t5_no_done", 32'(done_cnt - d1), 32'd0);
        check("t5_period",  period, 32'd10);
        check("t5_high",    high,   32'd3);
        check("t5_valid",   32'(valid), 32'd1);
        check("t5_busy",    32'(busy),  32'd0);

        // CW=8 overflow: pin rises and stays high
        pwm_in = 1'b0;
        cycles(5);
        en8 = 1'b1;
        cycles(3);
        pwm_in   = 1'b1;
        rise_cyc = cyc_cnt;
        cycles(300);
        check("t6_ovf_count",  32'(ovf8_cnt), 32'd1);
        check("t6_ovf_timing", 32'(ovf8_cyc - rise_cyc), 32'd259);
        check("t6_no_done",    32'(done8_cnt), 32'd0);
        check("t6_period",     32'(period8), 32'd0);
        check("t6_high",       32'(high8),   32'd0);
        check("t6_valid",      32'(valid8),  32'd0);
        check("t6_busy_arm",   32'(busy8),   32'd1);

        // Asynchronous reset during ACTIVE
        pwm_in = 1'b0;
        cycles(5);
        en = 1'b1;
        cycles(3);
        pwm_in = 1'b1;
        cycles(6);
        check("t7_pre_busy",  32'(busy),  32'd1);
        check("t7_pre_valid", 32'(valid), 32'd1);
        PRESETn = 1'b0;
        #1;
        check("t7_period", period, 32'd0);
        check("t7_high",   high,   32'd0);
        check("t7_valid",  32'(valid), 32'd0);
        check("t7_busy",   32'(busy),  32'd0);
        check("t7_done",   32'(done),  32'd0);
        check("t7_busy8",  32'(busy8), 32'd0);
        cycles(2);
        PRESETn = 1'b1;
        cycles(2);

        check("main_no_ovf", 32'(ovf_cnt), 32'd0);
        check("done_ovf_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
